// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word, memory-arbiter state encoding and the
// default word returned when the arbiter watchdog aborts an access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  localparam word_t ARB_ABORT_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts cycles spent in an access without a RAM completion
// and flags expiry when the count reaches TIMEOUT.
module arb_watchdog #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  // Saturates at TIMEOUT; the arbiter leaves the access that same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TIMEOUT)) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == TIMEOUT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Optional round-robin on conflicts when MEM_ARB_FAIR_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter word_t       ABORT_WORD = ARB_ABORT_WORD
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic       ram_ready,
  output logic       arb_err,
  output arb_state_t state_dbg
);

  arb_state_t state, next_state;
  logic       d_req, in_acc, expire, abort, complete, pick_d;

  // Handshake: a request stays asserted with stable address/data until its
  // wait drops; the access completes in the cycle ram_ready (or abort) is seen.
  assign d_req    = dREN | dWEN;
  assign in_acc   = (state == IACC) || (state == DACC);
  assign abort    = in_acc & expire & ~ram_ready;
  assign complete = in_acc & (ram_ready | expire);

  arb_watchdog #(.TIMEOUT(8'(TIMEOUT))) u_watchdog (
    .clk    (CLK),
    .rst    (RST),
    .clear  (state == IDLE),
    .enable (in_acc & ~ram_ready),
    .expire (expire)
  );

`ifdef MEM_ARB_FAIR_EN
  logic last_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_d <= 1'b0;
    end else if (state == IDLE && next_state == DACC) begin
      last_d <= 1'b1;
    end else if (state == IDLE && next_state == IACC) begin
      last_d <= 1'b0;
    end
  end

  assign pick_d = d_req & (~iREN | ~last_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      arb_err <= 1'b0;
    end else if (abort) begin
      arb_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          next_state = DACC;
        end else if (iREN) begin
          next_state = IACC;
        end
      end
      IACC, DACC: begin
        if (complete) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = ramload;
    dload    = ramload;
    iwait    = iREN & ~((state == IACC) & complete);
    dwait    = d_req & ~((state == DACC) & complete);
    case (state)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (abort) iload = ABORT_WORD;
      end
      DACC: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (abort) dload = ABORT_WORD;
      end
      default: ;
    endcase
    // Reset abandons any in-flight RAM access immediately.
    if (RST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
    end
  end

  assign state_dbg = state;

endmodule
